// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds one instruction at a time, fetching from an
// instruction memory with a bounded wait and a sticky timeout error.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     pc_reg;
    logic [31:0]     instr_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic            fetch_err_reg;
    logic            timed_out;

    assign timed_out = (state_reg == FETCH) && !imem_ready && (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    state_next = VALID;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            VALID: begin
                if (redirect || !stall) begin
                    state_next = FETCH;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = (state_reg == FETCH);
        instr_valid = (state_reg == VALID);
    end

    // Datapath: PC, held instruction, wait counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            instr_reg     <= NOP;
            wait_cnt_reg  <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        instr_reg    <= imem_rdata;
                        wait_cnt_reg <= '0;
                    end else if (timed_out) begin
                        fetch_err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                VALID: begin
                    // A taken branch overrides a downstream stall.
                    if (redirect) begin
                        pc_reg <= redirect_target & 32'hFFFF_FFFC;
                    end else if (!stall) begin
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign instr     = instr_reg;
    assign op        = instr_reg[6:0];
    assign fetch_err = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, fetch, stall, redirect,
// PC wrap, timeout and reset-in-flight, plus a TIMEOUT=1 instance.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [6:0]  op;

    logic        t1_ready;
    logic        t1_req, t1_valid, t1_err;
    logic [31:0] t1_addr, t1_instr, t1_pc, t1_pc_plus4;
    logic [6:0]  t1_op;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr(instr), .op(op),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'h0000_1000), .TIMEOUT(1)) dut_t1 (
        .clk(clk), .rst(rst),
        .imem_req(t1_req), .imem_addr(t1_addr),
        .imem_ready(t1_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(t1_valid), .instr(t1_instr), .op(t1_op),
        .pc(t1_pc), .pc_plus4(t1_pc_plus4), .fetch_err(t1_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        redirect = 1'b0; redirect_target = 32'h0; t1_ready = 1'b0;
        step(); step();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_op", {25'b0, op}, 32'h13);
        chk("rst_instr", instr, 32'h13);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("t1_rst_pc", t1_pc, 32'h1000);
        chk("t1_rst_pc4", t1_pc_plus4, 32'h1004);
        $display("txn reset: pc=%h op=%h", pc, op);

        // Release reset: IDLE cycle, then FETCH with always-ready memory
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("f1_req", {31'b0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h0);
        chk("t1_f_req", {31'b0, t1_req}, 32'd1);
        chk("t1_f_addr", t1_addr, 32'h1000);
        step();
        chk("v1_valid", {31'b0, instr_valid}, 32'd1);
        chk("v1_op", {25'b0, op}, 32'h33);
        chk("v1_pc", pc, 32'h0);
        chk("v1_req", {31'b0, imem_req}, 32'd0);
        chk("t1_err_set", {31'b0, t1_err}, 32'd1);
        chk("t1_err_req", {31'b0, t1_req}, 32'd0);
        $display("txn fetch: pc=%h instr=%h", pc, instr);
        step();
        chk("f2_addr", imem_addr, 32'h4);
        chk("f2_req", {31'b0, imem_req}, 32'd1);

        // Stall held three cycles in VALID
        imem_rdata = 32'h00A0_0093;
        step();
        chk("v2_instr", instr, 32'h00A0_0093);
        chk("v2_pc", pc, 32'h4);
        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h4);
            chk("stall_instr", instr, 32'h00A0_0093);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        $display("txn stall: pc=%h instr=%h", pc, instr);
        stall = 1'b0; imem_rdata = 32'h0000_0013;
        step();
        chk("unstall_addr", imem_addr, 32'h8);
        chk("unstall_req", {31'b0, imem_req}, 32'd1);
        step();
        chk("v3_req", {31'b0, imem_req}, 32'd0);
        chk("v3_pc", pc, 32'h8);

        // Redirect wins over stall
        redirect = 1'b1; redirect_target = 32'h0000_0102; stall = 1'b1;
        step();
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_valid", {31'b0, instr_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk("redir_pc", pc, 32'h0000_0100);
        chk("redir_pc4", pc_plus4, 32'h0000_0104);
        $display("txn redirect: pc=%h", pc);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        chk("wrap_fetch", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        chk("wrap_pc4", pc_plus4, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        // Redirect is ignored while fetching
        redirect = 1'b1; redirect_target = 32'h0000_0200;
        step();
        chk("fetch_redir_ign", pc, 32'h0);
        redirect = 1'b0;
        $display("txn wrap: pc=%h", pc);

        // Timeout: 16 non-ready FETCH cycles lead to ERR
        imem_ready = 1'b0;
        step();
        chk("to_addr", imem_addr, 32'h4);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_wait_req", {31'b0, imem_req}, 32'd1);
            chk("to_wait_err", {31'b0, fetch_err}, 32'd0);
        end
        step();
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_err_req", {31'b0, imem_req}, 32'd0);
        chk("to_err_valid", {31'b0, instr_valid}, 32'd0);
        imem_ready = 1'b1; redirect = 1'b1;
        step(); step();
        chk("err_hold", {31'b0, fetch_err}, 32'd1);
        chk("err_hold_req", {31'b0, imem_req}, 32'd0);
        redirect = 1'b0;
        $display("txn timeout: fetch_err=%b", fetch_err);
        rst = 1'b1;
        step();
        chk("err_clr", {31'b0, fetch_err}, 32'd0);
        chk("err_clr_pc", pc, 32'h0);

        // Reset asserted while a response is arriving in FETCH
        rst = 1'b0; imem_rdata = 32'h0000_0033;
        step(); step(); step();
        chk("pre_rst_addr", imem_addr, 32'h4);
        imem_rdata = 32'h0000_006F; rst = 1'b1;
        step();
        chk("rif_instr", instr, 32'h13);
        chk("rif_pc", pc, 32'h0);
        chk("rif_valid", {31'b0, instr_valid}, 32'd0);
        rst = 1'b0;
        step(); step();
        chk("rif_op", {25'b0, op}, 32'h6F);
        $display("txn reset_in_flight: pc=%h op=%h", pc, op);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
